uart_rx_oversampled: RTL and testbench
======================================

Name: uart_rx_oversampled

Overview:
- UART receiver consuming the 16x oversampling baud square wave from the team's baud-rate generator.
- Recovers 8N1 frames (generic width) from the serial `rx` line using mid-bit sampling.
- Presents each received byte with a one-cycle strobe and flags framing errors.
- Sits between the board RX pin and the byte-level consumer (e.g. a FIFO or echo logic).

Parameters:
- DATA_BITS, 8, number of data bits per frame, LSB first.
- SAMPLING_RATE, 16, baud-wave rising edges per bit period; must be even and at least 4.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- baud  input  1  oversampling square wave, same clk domain; each rising edge is one sample tick.
- rx  input  1  asynchronous serial line, idle high.
- data  output  DATA_BITS  last correctly framed byte.
- received  output  1  one-clk pulse when `data` updates.
- frame_err  output  1  high after a frame with a bad stop bit.
- busy  output  1  high while in any state other than IDLE.

Behaviour:
- **Clock and reset.** One clock (`clk`); reset is synchronous and active-high (`rst`). Reset values:
  - data=0, received=0, frame_err=0, busy=0.
  - State IDLE; internal counters 0.
  - rx synchroniser stages 1; baud delay register 0.
- **Tick generation.** `baud` is registered into `baud_q`. tick = baud & ~baud_q, combinational. The FSM advances only on clk edges where tick=1.
- **RX synchroniser.** `rx` passes through 2 flip-flops to give `rx_s`. Only `rx_s` is used downstream.
- **Counters.**
  - Sample counter `cnt`: 0..SAMPLING_RATE-1.
  - Bit index `idx`: 0..DATA_BITS-1.
  - Shift register `sh`, DATA_BITS wide.
- **State IDLE.** On a tick with rx_s=0: go to START, cnt=0.
- **State START.** On each tick, cnt increments.
  - At the tick where cnt==SAMPLING_RATE/2-1 (7): if rx_s=0, go to DATA with cnt=0, idx=0.
  - Otherwise it is a glitch: go to IDLE, no outputs change.
- **State DATA.** On each tick, cnt increments.
  - At cnt==SAMPLING_RATE-1: sh = {rx_s, sh[DATA_BITS-1:1]} (LSB first), cnt=0.
  - If idx==DATA_BITS-1, go to STOP; else idx increments.
- **State STOP.** At cnt==SAMPLING_RATE-1:
  - If rx_s=1: data<=sh, received=1 for exactly the next clk cycle, frame_err<=0, go to IDLE.
  - If rx_s=0: frame_err<=1, data unchanged, no received pulse, go to BREAK.
- **State BREAK.** Waits for a tick with rx_s=1, then goes to IDLE. A line held low never starts a spurious frame.
- **frame_err.** Level signal. Holds until the next successful frame or reset.
- **received.** High exactly one clk cycle, registered, starting on the edge that processed the stop-bit tick. It is never high on two consecutive cycles.
- **Latency.** The stop-bit sample is taken SAMPLING_RATE/2 + (DATA_BITS+1)*SAMPLING_RATE ticks after start detection.
- **Back-to-back frames.** After a good stop bit the FSM is in IDLE mid-stop-bit, so a start edge immediately following the stop bit is captured.
- **busy.** Equals (state != IDLE).
- **Reset during a frame.** Reset mid-frame aborts it immediately and returns all outputs and state to reset values on that edge.
- **rx/baud changes between ticks.** These are ignored except for synchroniser and `baud_q` updates.

Test Plan:
- **Setup for all scenarios.** Drive baud toggling every 2 clk, giving a tick every 4 clk and 1 bit = 64 clk.
- **Reset.** rst=1 for 3 clk with rx=1 -> data=0x00, received=0, frame_err=0, busy=0.
- **Single good frame.** Send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1 LSB first, stop 1) -> exactly one received pulse; data=0xA5, frame_err=0; busy falls in the same cycle received rises.
- **Start glitch.** rx low for 4 ticks (16 clk), then high for 20 bit-times -> busy rises then falls, no received pulse, data stays 0xA5.
- **Framing error, break, recovery.**
  - Send 0x3C with stop=0, then hold rx=0 for 20 bit-times -> frame_err=1, no received pulse, data=0xA5, busy stays high (BREAK) for the whole low period.
  - Release rx, then send 0x5A -> received pulse, data=0x5A, frame_err=0.
- **Reset mid-frame.** Assert rst during data bit 3 of 0x81 -> outputs return to reset values. Then send 0xFF -> data=0xFF, one received pulse.
- **Back-to-back frames.** Send 0x00 then 0xFF with zero idle bits -> two received pulses 10 bit-times (640 clk) apart, data=0x00 then 0xFF, frame_err=0.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// 8N1-style UART receiver driven by a 16x oversampling baud square wave.
// Each data bit is sampled at the middle of its bit period, and framing errors are flagged.
module uart_rx_oversampled #(
    parameter int DATA_BITS     = 8,
    parameter int SAMPLING_RATE = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 baud_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 received_o,
    output logic                 frame_err_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(SAMPLING_RATE);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(SAMPLING_RATE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLING_RATE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 received_q, received_d;
    logic                 frame_err_q, frame_err_d;
    logic                 baud_q;
    logic                 rx_meta_q, rx_s_q;
    logic                 tick;

    assign tick = baud_i & ~baud_q;

    // The synchroniser resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_q        <= '0;
            data_q      <= '0;
            received_q  <= 1'b0;
            frame_err_q <= 1'b0;
            baud_q      <= 1'b0;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sh_q        <= sh_d;
            data_q      <= data_d;
            received_q  <= received_d;
            frame_err_q <= frame_err_d;
            baud_q      <= baud_i;
            rx_meta_q   <= rx_i;
            rx_s_q      <= rx_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        sh_d        = sh_q;
        data_d      = data_q;
        received_d  = 1'b0;
        frame_err_d = frame_err_q;

        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                // A start bit that is no longer low at its midpoint is treated as a glitch.
                START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = rx_s_q ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        sh_d  = (sh_q >> 1) | (DATA_BITS'(rx_s_q) << (DATA_BITS - 1));
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = STOP;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                // Returning to IDLE mid-stop-bit lets a back-to-back start edge be caught.
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (rx_s_q) begin
                            data_d      = sh_q;
                            received_d  = 1'b1;
                            frame_err_d = 1'b0;
                            state_d     = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign data_o      = data_q;
    assign received_o  = received_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: a table of frames plus hand-written
// sequences for glitch, mid-frame reset and back-to-back frames.
module tb_uart_rx_oversampled;

    localparam int BIT_CLKS = 64;

    typedef struct {
        logic [7:0] txData;
        logic       stopBit;
        int         holdBits;
        int         expPulses;
        logic [7:0] expData;
        logic       expFrameErr;
    } vector_t;

    logic       clk;
    logic       rst;
    logic       baud;
    logic       rx;
    logic [7:0] dataOut;
    logic       received;
    logic       frameErr;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;
    int pulseCount = 0;
    int doublePulses = 0;
    int busyRises = 0;
    logic busyAtPulse = 1'b0;
    logic prevReceived = 1'b0;
    logic prevBusy = 1'b0;
    logic [7:0] pulseData [16];
    int pulseCycle [16];

    vector_t vectors [4];

    uart_rx_oversampled #(
        .DATA_BITS    (8),
        .SAMPLING_RATE(16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .baud_i     (baud),
        .rx_i       (rx),
        .data_o     (dataOut),
        .received_o (received),
        .frame_err_o(frameErr),
        .busy_o     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud wave toggles every 2 clocks, giving one sample tick every 4 clocks.
    initial begin
        baud = 1'b0;
        forever begin
            repeat (2) @(posedge clk);
            #1 baud = ~baud;
        end
    end

    // Records every received pulse, its data and timing, and busy rising edges.
    always @(negedge clk) begin
        cycleCount++;
        if (received) begin
            if (prevReceived) doublePulses++;
            if (pulseCount < 16) begin
                pulseData[pulseCount]  = dataOut;
                pulseCycle[pulseCount] = cycleCount;
            end
            pulseCount++;
            busyAtPulse = busy;
        end
        if (busy && !prevBusy) busyRises++;
        prevReceived = received;
        prevBusy     = busy;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called right at a rising edge; drives rx and holds it for nClks clocks.
    task automatic applyStimulus(input logic value, input int nClks);
        #1 rx = value;
        repeat (nClks) @(posedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] value, input logic stopBit);
        applyStimulus(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) applyStimulus(value[i], BIT_CLKS);
        applyStimulus(stopBit, BIT_CLKS);
    endtask

    task automatic sampleNow();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int p0;
        int r0;
        logic [7:0] lastGood;

        vectors[0] = '{txData: 8'hA5, stopBit: 1'b1, holdBits: 0,  expPulses: 1, expData: 8'hA5, expFrameErr: 1'b0};
        vectors[1] = '{txData: 8'h3C, stopBit: 1'b0, holdBits: 20, expPulses: 0, expData: 8'hA5, expFrameErr: 1'b1};
        vectors[2] = '{txData: 8'h5A, stopBit: 1'b1, holdBits: 0,  expPulses: 1, expData: 8'h5A, expFrameErr: 1'b0};
        vectors[3] = '{txData: 8'hC3, stopBit: 1'b1, holdBits: 0,  expPulses: 1, expData: 8'hC3, expFrameErr: 1'b0};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        sampleNow();
        checkOutput("resetData", 32'(dataOut), 32'h00);
        checkOutput("resetReceived", 32'(received), 32'h0);
        checkOutput("resetFrameErr", 32'(frameErr), 32'h0);
        checkOutput("resetBusy", 32'(busy), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        applyStimulus(1'b1, 2 * BIT_CLKS);

        lastGood = 8'h00;
        for (int v = 0; v < 4; v++) begin
            p0 = pulseCount;
            sendFrame(vectors[v].txData, vectors[v].stopBit);
            for (int b = 0; b < vectors[v].holdBits; b++) begin
                applyStimulus(1'b0, BIT_CLKS);
                sampleNow();
                checkOutput($sformatf("breakBusy%0d_%0d", v, b), 32'(busy), 32'h1);
                @(posedge clk);
            end
            applyStimulus(1'b1, 2 * BIT_CLKS);
            sampleNow();
            checkOutput($sformatf("vecPulses%0d", v), 32'(pulseCount - p0), 32'(vectors[v].expPulses));
            checkOutput($sformatf("vecData%0d", v), 32'(dataOut), 32'(vectors[v].expData));
            checkOutput($sformatf("vecFrameErr%0d", v), 32'(frameErr), 32'(vectors[v].expFrameErr));
            checkOutput($sformatf("vecBusyIdle%0d", v), 32'(busy), 32'h0);
            if (vectors[v].expPulses == 1) begin
                checkOutput($sformatf("vecBusyAtPulse%0d", v), 32'(busyAtPulse), 32'h0);
                lastGood = vectors[v].expData;
            end
            @(posedge clk);
        end

        // Start glitch: 4 ticks low must not produce a frame.
        p0 = pulseCount;
        r0 = busyRises;
        applyStimulus(1'b0, 16);
        applyStimulus(1'b1, 20 * BIT_CLKS);
        sampleNow();
        checkOutput("glitchBusyRose", 32'(busyRises - r0), 32'h1);
        checkOutput("glitchBusyIdle", 32'(busy), 32'h0);
        checkOutput("glitchNoPulse", 32'(pulseCount - p0), 32'h0);
        checkOutput("glitchData", 32'(dataOut), 32'(lastGood));
        @(posedge clk);

        // Reset in the middle of data bit 3 of 0x81.
        applyStimulus(1'b0, BIT_CLKS);
        applyStimulus(1'b1, BIT_CLKS);
        applyStimulus(1'b0, BIT_CLKS);
        applyStimulus(1'b0, BIT_CLKS);
        applyStimulus(1'b0, 32);
        sampleNow();
        checkOutput("midFrameBusy", 32'(busy), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        sampleNow();
        checkOutput("midResetData", 32'(dataOut), 32'h00);
        checkOutput("midResetReceived", 32'(received), 32'h0);
        checkOutput("midResetFrameErr", 32'(frameErr), 32'h0);
        checkOutput("midResetBusy", 32'(busy), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        applyStimulus(1'b1, 2 * BIT_CLKS);
        p0 = pulseCount;
        sendFrame(8'hFF, 1'b1);
        applyStimulus(1'b1, 2 * BIT_CLKS);
        sampleNow();
        checkOutput("postResetPulses", 32'(pulseCount - p0), 32'h1);
        checkOutput("postResetData", 32'(dataOut), 32'hFF);
        checkOutput("postResetFrameErr", 32'(frameErr), 32'h0);
        @(posedge clk);

        // Back-to-back frames with no idle bits between them.
        p0 = pulseCount;
        sendFrame(8'h00, 1'b1);
        sendFrame(8'hFF, 1'b1);
        applyStimulus(1'b1, 2 * BIT_CLKS);
        sampleNow();
        checkOutput("b2bPulses", 32'(pulseCount - p0), 32'h2);
        checkOutput("b2bFirstData", 32'(pulseData[p0]), 32'h00);
        checkOutput("b2bSecondData", 32'(pulseData[p0 + 1]), 32'hFF);
        checkOutput("b2bSpacing", 32'(pulseCycle[p0 + 1] - pulseCycle[p0]), 32'd640);
        checkOutput("b2bFrameErr", 32'(frameErr), 32'h0);
        checkOutput("b2bData", 32'(dataOut), 32'hFF);
        checkOutput("noDoublePulse", 32'(doublePulses), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
